// File: rtl/fmadd_pn_arbiter.sv
// Round-robin arbiter sharing one FMADD post-normalization datapath
// between the FMADD lane (0) and the FADD/FSUB lane (1); 2-stage pipe.
module fmadd_pn_arbiter #(
  parameter int MAN = 22,
  parameter int EXP = 7
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2*MAN+3:0] req0_mant,
  input  logic [EXP:0]     req0_exp,
  input  logic [5:0]       req0_ctl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2*MAN+3:0] req1_mant,
  input  logic [EXP:0]     req1_exp,
  input  logic [5:0]       req1_ctl,
  output logic [2*MAN+3:0] pn_mant_o,
  output logic [EXP:0]     pn_exp_o,
  output logic [5:0]       pn_ctl_o,
  input  logic [MAN+1:0]   pn_mant_i,
  input  logic [EXP+1:0]   pn_exp_i,
  input  logic [2:0]       pn_grs_i,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [MAN+1:0]   res_mant,
  output logic [EXP+1:0]   res_exp,
  output logic [2:0]       res_grs,
  output logic             res_tag,
  output logic             busy
);

  logic             s1_v;
  logic             s1_tag;
  logic [2*MAN+3:0] s1_mant;
  logic [EXP:0]     s1_exp;
  logic [5:0]       s1_ctl;
  logic             s2_v;
  logic             s2_tag;
  logic [MAN+1:0]   s2_mant;
  logic [EXP+1:0]   s2_exp;
  logic [2:0]       s2_grs;
  logic             prio;

  logic s2_free;
  logic s1_adv;
  logic s1_free;
  logic grant0;
  logic grant1;
  logic accept;

  assign s2_free = !s2_v || res_ready;
  assign s1_adv  = s1_v && s2_free;
  assign s1_free = !s1_v || s1_adv;

  // Ties go to prio; a lone requester always wins.
  assign grant0 = req0_valid && (!req1_valid || !prio);
  assign grant1 = req1_valid && (!req0_valid || prio);

  assign req0_ready = rst_l && !flush && s1_free && grant0;
  assign req1_ready = rst_l && !flush && s1_free && grant1;
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      s1_v    <= 1'b0;
      s1_tag  <= 1'b0;
      s1_mant <= '0;
      s1_exp  <= '0;
      s1_ctl  <= '0;
      s2_v    <= 1'b0;
      s2_tag  <= 1'b0;
      s2_mant <= '0;
      s2_exp  <= '0;
      s2_grs  <= '0;
      prio    <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
    end else begin
      if (accept) begin
        s1_v    <= 1'b1;
        s1_tag  <= req1_ready;
        s1_mant <= req1_ready ? req1_mant : req0_mant;
        s1_exp  <= req1_ready ? req1_exp : req0_exp;
        s1_ctl  <= req1_ready ? req1_ctl : req0_ctl;
        prio    <= !req1_ready;
      end else if (s1_adv) begin
        s1_v <= 1'b0;
      end
      if (s1_adv) begin
        s2_v    <= 1'b1;
        s2_tag  <= s1_tag;
        s2_mant <= pn_mant_i;
        s2_exp  <= pn_exp_i;
        s2_grs  <= pn_grs_i;
      end else if (res_ready) begin
        s2_v <= 1'b0;
      end
    end
  end

  assign pn_mant_o = s1_mant;
  assign pn_exp_o  = s1_exp;
  assign pn_ctl_o  = s1_ctl;

  assign res_valid = s2_v;
  assign res_mant  = s2_mant;
  assign res_exp   = s2_exp;
  assign res_grs   = s2_grs;
  assign res_tag   = s2_tag;
  assign busy      = s1_v || s2_v;

endmodule

// File: tb/tb_fmadd_pn_arbiter.sv
// Randomized bench for fmadd_pn_arbiter with a queue-based reference
// model and a small stand-in post-normalization datapath.
module tb_fmadd_pn_arbiter;

  localparam int MAN = 22;
  localparam int EXP = 7;
  localparam int MW  = 2*MAN+4;
  localparam int RW  = MAN+2;

  typedef struct {
    logic [RW-1:0]  mant;
    logic [EXP+1:0] exp;
    logic [2:0]     grs;
    logic           tag;
  } res_t;

  logic clk = 1'b0;
  logic rst_l, flush;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [MW-1:0] req0_mant, req1_mant, pn_mant_o;
  logic [EXP:0]  req0_exp, req1_exp, pn_exp_o;
  logic [5:0]    req0_ctl, req1_ctl, pn_ctl_o;
  logic [RW-1:0] pn_mant_i, res_mant;
  logic [EXP+1:0] pn_exp_i, res_exp;
  logic [2:0]    pn_grs_i, res_grs;
  logic res_valid, res_ready, res_tag, busy;

  int n_checks = 0;
  int n_fail = 0;

  res_t q[$];
  bit   front_s2;
  bit   prio;
  bit   known;

  always #5 clk = ~clk;

  fmadd_pn_arbiter #(.MAN(MAN), .EXP(EXP)) dut (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mant(req0_mant), .req0_exp(req0_exp), .req0_ctl(req0_ctl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mant(req1_mant), .req1_exp(req1_exp), .req1_ctl(req1_ctl),
    .pn_mant_o(pn_mant_o), .pn_exp_o(pn_exp_o), .pn_ctl_o(pn_ctl_o),
    .pn_mant_i(pn_mant_i), .pn_exp_i(pn_exp_i), .pn_grs_i(pn_grs_i),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mant(res_mant), .res_exp(res_exp), .res_grs(res_grs),
    .res_tag(res_tag), .busy(busy)
  );

  // Stand-in normalizer: a carry shifts right one and bumps the exponent.
  function automatic res_t dp(logic [MW-1:0] m, logic [EXP:0] e,
                              logic [5:0] c);
    res_t r;
    if (c[5]) begin
      r.mant = {1'b1, m[MW-1:MW-RW+1]};
      r.grs  = {m[MW-RW], m[MW-RW-1], |m[MW-RW-2:0]};
    end else begin
      r.mant = m[MW-1:MW-RW];
      r.grs  = {m[MW-RW-1], m[MW-RW-2], |m[MW-RW-3:0]};
    end
    r.exp = {1'b0, e} + (EXP+2)'(c[5]);
    r.tag = 1'b0;
    return r;
  endfunction

  always_comb begin
    res_t r;
    r = dp(pn_mant_o, pn_exp_o, pn_ctl_o);
    pn_mant_i = r.mant;
    pn_exp_i  = r.exp;
    pn_grs_i  = r.grs;
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(bit rst, bit fl, bit rr,
                      bit v0, logic [MW-1:0] m0, logic [EXP:0] e0,
                      logic [5:0] c0,
                      bit v1, logic [MW-1:0] m1, logic [EXP:0] e1,
                      logic [5:0] c1);
    bit s2occ, s1occ, adv, s1free, g0, g1, er0, er1;
    res_t r;
    @(negedge clk);
    rst_l = rst; flush = fl; res_ready = rr;
    req0_valid = v0; req0_mant = m0; req0_exp = e0; req0_ctl = c0;
    req1_valid = v1; req1_mant = m1; req1_exp = e1; req1_ctl = c1;
    #1;
    s2occ  = q.size() > 0 && front_s2;
    s1occ  = q.size() == 2 || (q.size() == 1 && !front_s2);
    adv    = s1occ && (!s2occ || rr);
    s1free = !s1occ || adv;
    g0     = v0 && (!v1 || !prio);
    g1     = v1 && (!v0 || prio);
    er0    = rst && !fl && s1free && g0;
    er1    = rst && !fl && s1free && g1;
    check("req0_ready", 64'(req0_ready), 64'(er0));
    check("req1_ready", 64'(req1_ready), 64'(er1));
    if (known) begin
      check("res_valid", 64'(res_valid), 64'(s2occ));
      check("busy", 64'(busy), 64'(q.size() > 0));
      if (s2occ) begin
        check("res_mant", 64'(res_mant), 64'(q[0].mant));
        check("res_exp", 64'(res_exp), 64'(q[0].exp));
        check("res_grs", 64'(res_grs), 64'(q[0].grs));
        check("res_tag", 64'(res_tag), 64'(q[0].tag));
      end
    end
    if (!rst) begin
      q.delete(); front_s2 = 0; prio = 0; known = 1;
    end else if (fl) begin
      q.delete(); front_s2 = 0;
    end else begin
      if (s2occ && rr) void'(q.pop_front());
      front_s2 = adv ? 1'b1 : (s2occ && !rr);
      if (er0 || er1) begin
        r = er1 ? dp(m1, e1, c1) : dp(m0, e0, c0);
        r.tag = er1;
        q.push_back(r);
        prio = !er1;
      end
    end
  endtask

  task automatic idle(bit rr);
    step(1, 0, rr, 0, '0, '0, '0, 0, '0, '0, '0);
  endtask

  function automatic logic [MW-1:0] rmant();
    return MW'({$urandom, $urandom});
  endfunction

  initial begin
    known = 0; prio = 0; front_s2 = 0;
    step(0, 0, 1, 0, '0, '0, '0, 0, '0, '0, '0);
    step(0, 0, 1, 0, '0, '0, '0, 0, '0, '0, '0);
    idle(1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_mant", 64'(res_mant), 64'd0);
    check("rst_pn_mant", 64'(pn_mant_o), 64'd0);

    step(1, 0, 1, 1, 48'h800000000000, 8'h7F, 6'b001000,
         0, '0, '0, '0);
    idle(1);
    idle(1);
    check("dir0_mant", 64'(res_mant), 64'h800000);
    check("dir0_exp", 64'(res_exp), 64'h07F);
    check("dir0_grs", 64'(res_grs), 64'd0);
    check("dir0_tag", 64'(res_tag), 64'd0);

    step(1, 0, 1, 0, '0, '0, '0,
         1, 48'hC00000000000, 8'h80, 6'b101000);
    idle(1);
    idle(1);
    check("dir1_mant", 64'(res_mant), 64'hE00000);
    check("dir1_exp", 64'(res_exp), 64'h081);
    check("dir1_tag", 64'(res_tag), 64'd1);

    // Contention with stalls, then flush while full, then reset mid-stream.
    for (int i = 0; i < 8; i++)
      step(1, 0, i < 3 || i > 5, 1, rmant(), 8'($urandom), 6'($urandom),
           1, rmant(), 8'($urandom), 6'($urandom));
    step(1, 0, 0, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    step(1, 1, 0, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    step(1, 0, 1, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    step(1, 0, 1, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    step(0, 0, 1, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    step(1, 0, 1, 1, rmant(), 8'h11, 6'h00, 1, rmant(), 8'h22, 6'h00);
    idle(1);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) >= 2, $urandom_range(99) < 3,
           $urandom_range(99) < 70,
           $urandom_range(99) < 70, rmant(), 8'($urandom), 6'($urandom),
           $urandom_range(99) < 70, rmant(), 8'($urandom), 6'($urandom));
    end
    for (int i = 0; i < 4; i++) idle(1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
